// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch front end with skid buffer, redirect and fault handling
`timescale 1ns/1ps

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_WORDS = 128
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS) << 2;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        inflight_v;
    logic [31:0] inflight_pc;
    logic        skid_v;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;

    logic        pc_legal;
    logic        out_stall;
    logic        out_free;
    logic        issue_slot;
    logic        issue;

    // The memory sees the current PC directly; its data comes back one cycle later.
    assign imem_addr  = pc;

    assign pc_legal   = (pc[1:0] == 2'b00) && (pc < PC_LIMIT);
    assign out_stall  = out_valid & ~out_ready;
    assign out_free   = ~out_valid | out_ready;

    // An issue slot exists only when the returning word is guaranteed a home:
    // skid empty and the output not stalled. A slot with an illegal PC faults.
    assign issue_slot = (state == ST_RUN) & ~skid_v & ~out_stall & ~redirect_valid;
    assign issue      = issue_slot & pc_legal;

    // Fetch FSM: PC advance, in-flight read tracking and the sticky fault flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= 32'h0;
            fault       <= 1'b0;
        end else if (redirect_valid) begin
            // A redirect abandons the outstanding read and restarts cleanly.
            state      <= ST_RUN;
            pc         <= redirect_pc;
            inflight_v <= 1'b0;
            fault      <= 1'b0;
        end else begin
            inflight_v <= issue;
            if (issue) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
            if (issue_slot && !pc_legal) begin
                state <= ST_FAULT;
                fault <= 1'b1;
            end
        end
    end

    // Return routing: refill the output register, parking returns in the skid when stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_inst  <= 32'h0;
            out_pc    <= 32'h0;
            skid_v    <= 1'b0;
            skid_inst <= 32'h0;
            skid_pc   <= 32'h0;
        end else if (redirect_valid) begin
            // Everything buffered belongs to the old path; any handshake this cycle already happened.
            out_valid <= 1'b0;
            skid_v    <= 1'b0;
        end else if (out_free) begin
            if (skid_v) begin
                // Older skid entry goes first; a same-cycle return takes its place.
                out_valid <= 1'b1;
                out_inst  <= skid_inst;
                out_pc    <= skid_pc;
                if (inflight_v) begin
                    skid_inst <= imem_inst;
                    skid_pc   <= inflight_pc;
                end else begin
                    skid_v <= 1'b0;
                end
            end else if (inflight_v) begin
                out_valid <= 1'b1;
                out_inst  <= imem_inst;
                out_pc    <= inflight_pc;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (inflight_v) begin
            // Output held by back-pressure: the word returning now must not be lost.
            skid_v    <= 1'b1;
            skid_inst <= imem_inst;
            skid_pc   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
`timescale 1ns/1ps

module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam int          MEM_WORDS = 128;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        fault;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] sb [$];
    logic [31:0] mem [MEM_WORDS];

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = exp_inst(32'(i) << 2);
    end

    // Synchronous-read instruction memory
    always @(posedge clock) imem_inst <= mem[imem_addr[8:2]];

    // Scoreboard: every accepted transfer must be the next expected PC and its word
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_transfer: got pc %h inst %h, required no transfer", out_pc, out_inst);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (out_pc !== e || out_inst !== exp_inst(e)) begin
                    mismatched++;
                    $display("FAIL transfer: got pc %h inst %h, required pc %h inst %h", out_pc, out_inst, e, exp_inst(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name, output int n);
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d transfers missing after %0d cycles, required 0", name, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        repeat (3) step();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        compared++;
        if (fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault: got %b, required 0", fault); end
        compared++;
        if (imem_addr !== RESET_PC) begin mismatched++; $display("FAIL reset_pc: got %h, required %h", imem_addr, RESET_PC); end
        compared++;
        if (out_pc !== 32'h0 || out_inst !== 32'h0) begin
            mismatched++; $display("FAIL reset_out_regs: got pc %h inst %h, required 0/0", out_pc, out_inst);
        end
    endtask

    task automatic test_latency();
        int n;
        sb.push_back(32'h0);
        reset = 1'b0;
        step();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL latency_cyc1: got out_valid %b, required 0", out_valid); end
        step();
        compared++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== exp_inst(32'h0)) begin
            mismatched++;
            $display("FAIL latency_cyc2: got valid %b pc %h inst %h, required 1 0 %h", out_valid, out_pc, out_inst, exp_inst(32'h0));
        end
        drain("latency", n);
        compared++;
        if (n != 1) begin mismatched++; $display("FAIL latency_accept: got %0d cycles, required 1", n); end
    endtask

    task automatic test_stall();
        int n;
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== exp_inst(32'h4) || imem_addr !== 32'hC) begin
                mismatched++;
                $display("FAIL stall_hold: got valid %b pc %h inst %h addr %h, required 1 4 %h c",
                         out_valid, out_pc, out_inst, imem_addr, exp_inst(32'h4));
            end
        end
        for (int a = 4; a <= 28; a += 4) sb.push_back(32'(a));
        drain("stall", n);
        compared++;
        if (n != 8) begin mismatched++; $display("FAIL stall_release_cycles: got %0d, required 8", n); end
    endtask

    task automatic test_redirect();
        int n;
        step();
        sb.push_back(32'h20);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4;
        step();
        redirect_valid = 1'b0; out_ready = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h4) begin
            mismatched++; $display("FAIL redirect_flush: got valid %b addr %h, required 0 4", out_valid, imem_addr);
        end
        step();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL redirect_cyc2: got out_valid %b, required 0", out_valid); end
        step();
        compared++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_inst !== exp_inst(32'h4)) begin
            mismatched++; $display("FAIL redirect_cyc3: got valid %b pc %h inst %h, required 1 4 %h", out_valid, out_pc, out_inst, exp_inst(32'h4));
        end
        sb.push_back(32'h4); sb.push_back(32'h8);
        drain("redirect", n);
        compared++;
        if (n != 2) begin mismatched++; $display("FAIL redirect_stream_cycles: got %0d, required 2", n); end
    endtask

    task automatic test_last_word();
        int n;
        sb.push_back(32'h1FC);
        redirect_valid = 1'b1; redirect_pc = 32'h1FC;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        step();
        compared++;
        if (out_valid !== 1'b0 || fault !== 1'b0) begin
            mismatched++; $display("FAIL last_cyc2: got valid %b fault %b, required 0 0", out_valid, fault);
        end
        step();
        compared++;
        if (out_valid !== 1'b1 || out_pc !== 32'h1FC || out_inst !== exp_inst(32'h1FC) || fault !== 1'b1) begin
            mismatched++;
            $display("FAIL last_word: got valid %b pc %h inst %h fault %b, required 1 1fc %h 1", out_valid, out_pc, out_inst, fault, exp_inst(32'h1FC));
        end
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (out_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 32'h200) begin
                mismatched++; $display("FAIL last_fault_hold: got valid %b fault %b addr %h, required 0 1 200", out_valid, fault, imem_addr);
            end
        end
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL last_delivered: got %0d pending, required 0", sb.size()); sb.delete(); end
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        compared++;
        if (fault !== 1'b0) begin mismatched++; $display("FAIL fault_clear: got %b, required 0", fault); end
        drain("resume", n);
        compared++;
        if (n != 5) begin mismatched++; $display("FAIL resume_cycles: got %0d, required 5", n); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        step();
        redirect_valid = 1'b0;
        compared++;
        if (out_valid !== 1'b0 || fault !== 1'b0) begin
            mismatched++; $display("FAIL misaligned_cyc1: got valid %b fault %b, required 0 0", out_valid, fault);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            compared++;
            if (out_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 32'h6) begin
                mismatched++; $display("FAIL misaligned_fault: got valid %b fault %b addr %h, required 0 1 6", out_valid, fault, imem_addr);
            end
        end
    endtask

    task automatic test_reset_midstall();
        int n;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        redirect_valid = 1'b0;
        repeat (3) step();
        compared++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== 32'h8) begin
            mismatched++; $display("FAIL midstall_setup: got valid %b pc %h addr %h, required 1 0 8", out_valid, out_pc, imem_addr);
        end
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (out_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== RESET_PC || out_pc !== 32'h0 || out_inst !== 32'h0) begin
            mismatched++;
            $display("FAIL async_reset: got valid %b fault %b addr %h pc %h inst %h, required 0 0 %h 0 0",
                     out_valid, fault, imem_addr, out_pc, out_inst, RESET_PC);
        end
        repeat (2) step();
        sb.push_back(32'h0); sb.push_back(32'h4);
        reset = 1'b0;
        drain("after_reset", n);
        compared++;
        if (n != 4) begin mismatched++; $display("FAIL after_reset_cycles: got %0d, required 4", n); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_redirect();
        test_last_word();
        test_misaligned();
        test_reset_midstall();
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
